// File: rtl/imem_pkg.sv
// Shared definitions for the loadable instruction memory: FSM state encoding and
// the default word used for cleared, unimplemented and not-yet-valid locations.
package imem_pkg;

   localparam logic [1:0] ST_CLEAR = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_LOAD  = 2'd2;

   typedef enum logic [1:0] {
      StClear = ST_CLEAR,
      StRun   = ST_RUN,
      StLoad  = ST_LOAD
   } imem_state_e;

   localparam logic [7:0] IMEM_NOP_DEFAULT = 8'h00;

endpackage

// File: rtl/instr_mem_loadable_if.sv
// Loader and fetch bus of the instruction memory. The master side is the host/loader
// plus PC/decode logic; the slave side is the memory itself.
interface instr_mem_loadable_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
) ();

   logic              load_start;
   logic              load_valid;
   logic              load_last;
   logic [DATA_W-1:0] load_data;
   logic              load_ready;
   logic              load_done;
   logic              fetch_en;
   logic              stall;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] instruction_out;
   logic              instr_valid;
   logic              busy;

   modport master (
      output load_start, load_valid, load_last, load_data, fetch_en, stall, address,
      input  load_ready, load_done, instruction_out, instr_valid, busy
   );

   modport slave (
      input  load_start, load_valid, load_last, load_data, fetch_en, stall, address,
      output load_ready, load_done, instruction_out, instr_valid, busy
   );

endinterface

// File: rtl/imem_sp_ram.sv
// Single-port synchronous RAM with a registered read. Read data holds whenever no
// read is issued, which gives the fetch path its stall hold for free.
module imem_sp_ram #(
   parameter int unsigned DEPTH  = 32,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end else if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: self-clears after reset, accepts a streamed program
// load, then serves registered, stallable fetches with one cycle of latency.
module instr_mem_loadable
   import imem_pkg::*;
#(
   parameter int unsigned       DATA_W    = 8,
   parameter int unsigned       ADDR_W    = 5,
   parameter int unsigned       DEPTH     = 32,
   parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(IMEM_NOP_DEFAULT)
) (
   input logic                clk,
   input logic                rst_n,
   instr_mem_loadable_if.slave bus
);

   localparam int unsigned      PTR_W     = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   imem_state_e      state_q;
   logic [PTR_W-1:0] clr_cnt_q;
   logic [PTR_W-1:0] load_ptr_q;
   logic             load_ready_q;
   logic             load_done_q;
   logic             busy_q;
   logic             instr_valid_q;
   logic             out_nop_q;

   logic              addr_in_range;
   logic              fetch_go;
   logic              load_go;
   logic              load_end;
   logic              ram_we;
   logic              ram_re;
   logic [PTR_W-1:0]  ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   always_comb begin
      // Extra top bit keeps the compare correct when DEPTH == 2**ADDR_W.
      addr_in_range = ({1'b0, bus.address} < DEPTH_EXT);
      fetch_go      = (state_q == StRun) && !bus.load_start && bus.fetch_en && !bus.stall;
      load_go       = (state_q == StLoad) && bus.load_valid;
      load_end      = load_go && (bus.load_last || (load_ptr_q == LAST_PTR));

      ram_we    = 1'b0;
      ram_re    = 1'b0;
      ram_addr  = bus.address[PTR_W-1:0];
      ram_wdata = NOP_VALUE;
      case (state_q)
         StClear: begin
            ram_we   = 1'b1;
            ram_addr = clr_cnt_q;
         end
         StLoad: begin
            ram_we    = load_go;
            ram_addr  = load_ptr_q;
            ram_wdata = bus.load_data;
         end
         default: begin
            ram_re = fetch_go && addr_in_range;
         end
      endcase
   end

   imem_sp_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (PTR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StClear;
         clr_cnt_q     <= '0;
         load_ptr_q    <= '0;
         load_ready_q  <= 1'b0;
         load_done_q   <= 1'b0;
         busy_q        <= 1'b1;
         instr_valid_q <= 1'b0;
         out_nop_q     <= 1'b1;
      end else begin
         load_done_q <= 1'b0;
         case (state_q)
            StClear: begin
               if (clr_cnt_q == LAST_PTR) begin
                  clr_cnt_q <= '0;
                  state_q   <= StRun;
                  busy_q    <= 1'b0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + PTR_W'(1);
               end
            end
            StRun: begin
               if (bus.load_start) begin
                  state_q       <= StLoad;
                  load_ptr_q    <= '0;
                  load_ready_q  <= 1'b1;
                  busy_q        <= 1'b1;
                  instr_valid_q <= 1'b0;
                  out_nop_q     <= 1'b1;
               end else if (!bus.stall) begin
                  instr_valid_q <= bus.fetch_en;
                  // Out-of-range fetches return NOP without touching the RAM.
                  if (bus.fetch_en) begin
                     out_nop_q <= !addr_in_range;
                  end
               end
            end
            StLoad: begin
               if (load_end) begin
                  state_q      <= StRun;
                  load_ready_q <= 1'b0;
                  busy_q       <= 1'b0;
                  load_done_q  <= 1'b1;
               end else if (load_go) begin
                  load_ptr_q <= load_ptr_q + PTR_W'(1);
               end
            end
            default: begin
               state_q <= StClear;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.load_ready      = load_ready_q;
   assign bus.load_done       = load_done_q;
   assign bus.busy            = busy_q;
   assign bus.instr_valid     = instr_valid_q;
   assign bus.instruction_out = out_nop_q ? NOP_VALUE : ram_rdata;

endmodule
